// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble sequencing for the F/D -> A -> M pipeline
//
// Purpose:
//   Shadows the destination-register state of the instructions in A and M and
//   detects read-after-write hazards against the instruction in D (no forwarding,
//   register file written at the end of M). It drives the stall/flush/bubble
//   controls and keeps saturating counts of stall cycles and mispredict flushes.
//
// Ports:
//   clk          rising-edge clock
//   RESET_N      asynchronous active-low reset
//   dec_valid    D holds a real instruction
//   dec_rs/rt    source registers of D, qualified by dec_use_rs/dec_use_rt
//   dec_wrreg    D writes dec_wregno
//   mispred      A-stage mispredict (already qualified by A not-nop)
//   stall_F      hold PC and D this cycle
//   flush_D      squash the instruction in D
//   bubble_A     A receives a nop at the next edge
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of mispredict flushes

module pipe_hazard_ctrl #(
   parameter int REGNOBITS   = 6,
   parameter int CNTBITS     = 16,
   parameter int RESET_FLUSH = 2
) (
   input  logic                 clk,
   input  logic                 RESET_N,
   input  logic                 dec_valid,
   input  logic [REGNOBITS-1:0] dec_rs,
   input  logic                 dec_use_rs,
   input  logic [REGNOBITS-1:0] dec_rt,
   input  logic                 dec_use_rt,
   input  logic                 dec_wrreg,
   input  logic [REGNOBITS-1:0] dec_wregno,
   input  logic                 mispred,
   output logic                 stall_F,
   output logic                 flush_D,
   output logic                 bubble_A,
   output logic [CNTBITS-1:0]   stall_cnt,
   output logic [CNTBITS-1:0]   flush_cnt
);

   localparam int INITW = (RESET_FLUSH < 1) ? 1 : $clog2(RESET_FLUSH + 1);

   logic                 a_v_q, a_v_d;
   logic                 a_wr_q, a_wr_d;
   logic [REGNOBITS-1:0] a_regno_q, a_regno_d;
   logic                 m_v_q, m_v_d;
   logic                 m_wr_q, m_wr_d;
   logic [REGNOBITS-1:0] m_regno_q, m_regno_d;
   logic [INITW-1:0]     init_cnt_q, init_cnt_d;
   logic [CNTBITS-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNTBITS-1:0]   flush_cnt_q, flush_cnt_d;

   logic init;
   logic hit_rs, hit_rt, hazard;
   logic stall_i, flush_i, bubble_i;

   // Hazard detection and control priority. The internal controls exclude the
   // reset term so that RESET_N only reaches the outputs, never a flop D input;
   // while reset is held the flops ignore their D inputs anyway.
   always_comb begin
      init   = (init_cnt_q != '0);
      // The M term matters: the register file is written at the M edge while
      // D reads it combinationally in the same cycle.
      hit_rs = (a_v_q & a_wr_q & (a_regno_q == dec_rs)) |
               (m_v_q & m_wr_q & (m_regno_q == dec_rs));
      hit_rt = (a_v_q & a_wr_q & (a_regno_q == dec_rt)) |
               (m_v_q & m_wr_q & (m_regno_q == dec_rt));
      hazard = dec_valid & ((dec_use_rs & hit_rs) | (dec_use_rt & hit_rt));

      stall_i  = 1'b0;
      flush_i  = 1'b0;
      bubble_i = 1'b0;
      if (mispred) begin
         flush_i  = 1'b1;
         bubble_i = 1'b1;
      end else if (init) begin
         flush_i  = 1'b1;
         bubble_i = 1'b1;
      end else if (hazard) begin
         stall_i  = 1'b1;
         bubble_i = 1'b1;
      end
   end

   always_comb begin
      if (!RESET_N) begin
         stall_F  = 1'b0;
         flush_D  = 1'b1;
         bubble_A = 1'b1;
      end else begin
         stall_F  = stall_i;
         flush_D  = flush_i;
         bubble_A = bubble_i;
      end
   end

   // Next-state: A shadow moves into M unconditionally; a bubble or nop in D
   // leaves A invalid.
   always_comb begin
      m_v_d     = a_v_q;
      m_wr_d    = a_wr_q;
      m_regno_d = a_regno_q;

      a_v_d     = 1'b0;
      a_wr_d    = a_wr_q;
      a_regno_d = a_regno_q;
      if (!bubble_i && dec_valid) begin
         a_v_d     = 1'b1;
         a_wr_d    = dec_wrreg;
         a_regno_d = dec_wregno;
      end

      init_cnt_d = init ? (init_cnt_q - 1'b1) : init_cnt_q;

      stall_cnt_d = stall_cnt_q;
      if (stall_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      flush_cnt_d = flush_cnt_q;
      if (mispred && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         a_v_q       <= 1'b0;
         a_wr_q      <= 1'b0;
         a_regno_q   <= '0;
         m_v_q       <= 1'b0;
         m_wr_q      <= 1'b0;
         m_regno_q   <= '0;
         init_cnt_q  <= INITW'(RESET_FLUSH);
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         a_v_q       <= a_v_d;
         a_wr_q      <= a_wr_d;
         a_regno_q   <= a_regno_d;
         m_v_q       <= m_v_d;
         m_wr_q      <= m_wr_d;
         m_regno_q   <= m_regno_d;
         init_cnt_q  <= init_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
